// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
//  Module      : irq_request_latch
//  Description : Synchronises 16 raw interrupt lines, latches them as pending
//                requests, and runs the REQ/ACK/EOI handshake with the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_request_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SENS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_a,
  input  logic [7:0] irq_b,
  input  logic [7:0] mask_a,
  input  logic [7:0] mask_b,
  input  logic       ack,
  input  logic       ack_bank,
  input  logic [2:0] ack_code,
  input  logic       eoi,
  input  logic       ovf_clr,
  output logic [7:0] pend_a,
  output logic [7:0] pend_b,
  output logic       irq,
  output logic       busy,
  output logic       ovf
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_svc  = 2'd2;
  localparam logic       c_edge    = (EDGE_SENS != 0);

  logic [15:0] r_sync [SYNC_STAGES];
  logic [15:0] r_hist;
  logic [SYNC_STAGES:0] r_fill;
  logic [15:0] r_set;
  logic [15:0] r_pend;
  logic [15:0] r_vis;
  logic        r_ovf;
  logic        r_irq;
  logic        r_busy;
  logic [1:0]  r_state;

  logic [15:0] w_sync_q;
  logic        w_hist_valid;
  logic [15:0] w_set;
  logic [15:0] w_clr;
  logic [15:0] w_pend_nxt;
  logic        w_ovf_hit;
  logic        w_any_pend;
  logic [1:0]  w_state_nxt;

  // Bank B occupies the upper byte so {ack_bank, ack_code} indexes directly.
  generate
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
      if (g == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) r_sync[g] <= '0;
          else        r_sync[g] <= {irq_b, irq_a};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!rst_n) r_sync[g] <= '0;
          else        r_sync[g] <= r_sync[g-1];
        end
      end
    end
  endgenerate

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Edges are only trusted once the history flop holds a genuine post-reset
  // sample; a line held high across reset therefore never latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_set  <= '0;
    end else begin
      r_hist <= w_sync_q;
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_set  <= w_set;
    end
  end

  assign w_hist_valid = r_fill[SYNC_STAGES];
  assign w_set = c_edge ? (w_sync_q & ~r_hist & {16{w_hist_valid}}) : w_sync_q;

  assign w_clr      = (r_state == c_st_req && ack) ? (16'd1 << {ack_bank, ack_code}) : 16'd0;
  assign w_pend_nxt = (r_pend & ~w_clr) | r_set;
  assign w_ovf_hit  = c_edge && (|(r_set & r_pend));
  assign w_any_pend = |r_vis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_vis  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_vis  <= w_pend_nxt & ~{mask_b, mask_a};
      if (w_ovf_hit)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_any_pend) w_state_nxt = c_st_req;
      c_st_req: begin
        if (ack)              w_state_nxt = c_st_svc;
        else if (!w_any_pend) w_state_nxt = c_st_idle;
      end
      c_st_svc:  if (eoi) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt == c_st_req);
      r_busy  <= (w_state_nxt == c_st_svc);
    end
  end

  assign pend_a = r_vis[7:0];
  assign pend_b = r_vis[15:8];
  assign irq    = r_irq;
  assign busy   = r_busy;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_request_latch
//  Description : Cycle-by-cycle vector table plus a short handshake sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_a = '0, irq_b = '0, mask_a = '0, mask_b = '0;
  logic       ack = 1'b0, ack_bank = 1'b0, eoi = 1'b0, ovf_clr = 1'b0;
  logic [2:0] ack_code = '0;
  logic [7:0] pend_a, pend_b;
  logic       irq, busy, ovf;

  int tests_run = 0;
  int tests_failed = 0;

  irq_request_latch #(.SYNC_STAGES(2), .EDGE_SENS(1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_a(irq_a), .irq_b(irq_b),
    .mask_a(mask_a), .mask_b(mask_b), .ack(ack), .ack_bank(ack_bank),
    .ack_code(ack_code), .eoi(eoi), .ovf_clr(ovf_clr),
    .pend_a(pend_a), .pend_b(pend_b), .irq(irq), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] ia, ib, mb;
    logic       ak, bk;
    logic [2:0] cd;
    logic       eo, oc;
    logic [7:0] pa, pb;
    logic       ei, eb, eo_v;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input int n, input logic r, input logic [7:0] ia,
                            input logic [7:0] ib, input logic [7:0] mb,
                            input logic ak, input logic bk, input logic [2:0] cd,
                            input logic eo, input logic oc, input logic [7:0] pa,
                            input logic [7:0] pb, input logic ei, input logic eb,
                            input logic ev);
    vec_t t;
    t.r = r; t.ia = ia; t.ib = ib; t.mb = mb; t.ak = ak; t.bk = bk; t.cd = cd;
    t.eo = eo; t.oc = oc; t.pa = pa; t.pb = pb; t.ei = ei; t.eb = eb; t.eo_v = ev;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int idx, input logic [18:0] got,
                       input logic [18:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got pa=%h pb=%h irq=%b busy=%b ovf=%b, want pa=%h pb=%h irq=%b busy=%b ovf=%b",
               name, idx, got[18:11], got[10:3], got[2], got[1], got[0],
               exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    //  n  r  ia     ib     mb    ak bk cd eo oc  pa     pb     irq busy ovf
    v(2, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // reset, lines high
    v(4, 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // held high: no latch
    v(3, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v(3, 1, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // A3 rises
    v(1, 1, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h08, 8'h00, 0, 0, 0);
    v(1, 1, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h08, 8'h00, 1, 0, 0);
    v(1, 1, 8'h08, 8'h00, 8'h00, 1, 0, 3, 0, 0, 8'h00, 8'h00, 0, 1, 0); // ACK A/3
    v(1, 1, 8'h08, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    v(1, 1, 8'h08, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0); // EOI
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v(3, 1, 8'h01, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // A0 + B5 rise
    v(1, 1, 8'h01, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h01, 8'h20, 0, 0, 0);
    v(1, 1, 8'h01, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h01, 8'h20, 1, 0, 0);
    v(1, 1, 8'h01, 8'h20, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 0); // ACK A/0
    v(1, 1, 8'h01, 8'h20, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h20, 0, 0, 0); // EOI
    v(1, 1, 8'h01, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h20, 1, 0, 0); // one idle cycle
    v(1, 1, 8'h00, 8'h00, 8'h00, 1, 1, 5, 0, 0, 8'h00, 8'h00, 0, 1, 0); // ACK B/5
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    v(5, 1, 8'h00, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // B7 masked
    v(1, 1, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0, 0); // unmask
    v(1, 1, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h80, 1, 0, 0);
    v(1, 1, 8'h00, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0); // retract via mask
    v(1, 1, 8'h00, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v(1, 1, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0, 0);
    v(1, 1, 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h80, 1, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 1, 1, 7, 0, 0, 8'h00, 8'h00, 0, 1, 0); // ACK B/7
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    v(3, 1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // A2 rises
    v(1, 1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 0, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 0);
    v(3, 1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 0); // re-edge
    v(1, 1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 1); // OVF
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 1);
    v(3, 1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 1);
    v(1, 1, 8'h04, 8'h00, 8'h00, 1, 0, 2, 0, 1, 8'h04, 8'h00, 0, 1, 1); // set beats ACK, OVF_CLR
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h04, 8'h00, 0, 1, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h04, 8'h00, 0, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 1, 0, 2, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // ACK in IDLE
    v(3, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v(1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h01, 8'h00, 0, 0, 0);
    v(1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);
    v(1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h01, 8'h00, 1, 0, 0); // EOI in REQ
    v(1, 1, 8'h01, 8'h00, 8'h00, 1, 1, 3, 0, 0, 8'h01, 8'h00, 0, 1, 0); // ACK of empty bit
    v(1, 1, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h01, 8'h00, 0, 1, 0); // ACK in SERVICE
    v(1, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0); // reset in SERVICE
    v(4, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    v(1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].r; irq_a = vecs[i].ia; irq_b = vecs[i].ib; mask_b = vecs[i].mb;
      ack = vecs[i].ak; ack_bank = vecs[i].bk; ack_code = vecs[i].cd;
      eoi = vecs[i].eo; ovf_clr = vecs[i].oc;
      @(posedge clk); #1;
      check("vec", i, {pend_a, pend_b, irq, busy, ovf},
            {vecs[i].pa, vecs[i].pb, vecs[i].ei, vecs[i].eb, vecs[i].eo_v});
    end

    // ACK and EOI together in REQ: ACK taken, EOI ignored.
    @(negedge clk);
    ack = 1'b0; eoi = 1'b0; ovf_clr = 1'b0; irq_b = 8'h01;
    begin
      int n = 0;
      while (irq !== 1'b1 && n < 12) begin
        @(posedge clk); #1; n++;
      end
      check("hs_irq_wait", n, {pend_a, pend_b, irq, busy, ovf},
            {8'h00, 8'h01, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    ack = 1'b1; ack_bank = 1'b1; ack_code = 3'd0; eoi = 1'b1;
    @(posedge clk); #1;
    check("hs_ack_eoi", 0, {pend_a, pend_b, irq, busy, ovf}, {8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    ack = 1'b0; eoi = 1'b0;
    @(posedge clk); #1;
    check("hs_still_busy", 0, {pend_a, pend_b, irq, busy, ovf}, {8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    eoi = 1'b1;
    @(posedge clk); #1;
    check("hs_eoi", 0, {pend_a, pend_b, irq, busy, ovf}, {8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    eoi = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
